mac_filter_axil_regs: RTL and testbench

AXI4-Lite responder holding the MAC filter's control/status register file. Accepts single-beat writes and reads from the system AXI master (the port the block-design master VIP drives). Presents decoded configuration (enable, promiscuous, 48-bit station MAC) to the filter datapath and counts frames dropped by the filter. Sits between the AXI interconnect and the mac_filter datapath, one clock domain.

---
 rtl/mac_filter_regs_pkg.sv | 37 +++
 rtl/mac_filter_sat_counter.sv | 23 ++
 rtl/mac_filter_axil_regs.sv | 193 +++++++++++++++++++
 tb/tb_mac_filter_axil_regs.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_filter_regs_pkg.sv
// Register map, reset values, writable masks and AXI response codes for the MAC filter register file.
// Also provides the byte-lane merge helper shared by every RW register.
package mac_filter_regs_pkg;

  localparam logic [31:0] OFFS_CTRL     = 32'h00;
  localparam logic [31:0] OFFS_MAC_LO   = 32'h04;
  localparam logic [31:0] OFFS_MAC_HI   = 32'h08;
  localparam logic [31:0] OFFS_SCRATCH  = 32'h0C;
  localparam logic [31:0] OFFS_DROP_CNT = 32'h10;

  localparam logic [31:0] RST_CTRL      = 32'h0000_0000;
  localparam logic [31:0] RST_MAC_LO    = 32'h0000_0000;
  localparam logic [31:0] RST_MAC_HI    = 32'h0000_0000;
  localparam logic [31:0] RST_SCRATCH   = 32'h0000_0000;

  localparam logic [31:0] MASK_CTRL     = 32'h0000_0003;
  localparam logic [31:0] MASK_MAC_LO   = 32'hFFFF_FFFF;
  localparam logic [31:0] MASK_MAC_HI   = 32'h0000_FFFF;
  localparam logic [31:0] MASK_SCRATCH  = 32'hFFFF_FFFF;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_RESP} rd_state_t;

  // Only bytes enabled by strb and bits present in mask take the new value.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb,
                                             input logic [31:0] mask);
    logic [31:0] bm;
    bm = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}} & mask;
    return (old_val & ~bm) | (new_val & bm);
  endfunction

endpackage

// File: rtl/mac_filter_sat_counter.sv
// Saturating event counter; updates one cycle after inc/clr, clear has priority over inc.
// No backpressure: every inc strobe is accounted for until the counter saturates.
module mac_filter_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mac_filter_axil_regs.sv
// AXI4-Lite register file for the MAC filter; write commits when AW and W are both held, read data 1 cycle after AR.
// One write and one read outstanding at a time; readies drop while a response waits for BREADY/RREADY.
module mac_filter_axil_regs
  import mac_filter_regs_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic                    filter_en,
  output logic                    promisc,
  output logic [47:0]             mac_addr,
  input  logic                    drop_pulse
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("mac_filter_axil_regs: DATA_WIDTH must be 32");
  end

  wr_state_t             wr_state, wr_next;
  rd_state_t             rd_state, rd_next;
  logic                  init_q;
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-3:0] aw_word_q, wr_word;
  logic [31:0]           w_data_q, wr_data, wr_off, rd_off, rd_val;
  logic [3:0]            w_strb_q, wr_strb;
  logic [1:0]            rd_resp;
  logic [31:0]           ctrl_q, mac_lo_q, mac_hi_q, scratch_q, drop_cnt;
  logic                  unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Whichever channel is still live on the commit edge is taken straight from the bus.
  assign wr_word = (wr_state == WR_HAVE_AW) ? aw_word_q : S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign wr_data = (wr_state == WR_HAVE_W) ? w_data_q : S_AXI_WDATA;
  assign wr_strb = (wr_state == WR_HAVE_W) ? w_strb_q : S_AXI_WSTRB;
  assign wr_off  = 32'({wr_word, 2'b00});

  always_comb begin
    wr_next = wr_state;
    commit  = 1'b0;
    unique case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end else if (aw_hs) begin
          wr_next = WR_HAVE_AW;
        end else if (w_hs) begin
          wr_next = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: if (w_hs) begin
        commit  = 1'b1;
        wr_next = WR_RESP;
      end
      WR_HAVE_W: if (aw_hs) begin
        commit  = 1'b1;
        wr_next = WR_RESP;
      end
      WR_RESP: if (S_AXI_BREADY) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) wr_state <= WR_IDLE;
    else        wr_state <= wr_next;
  end

  assign S_AXI_BVALID = (wr_state == WR_RESP);

  // init_q delays the first ready assertion to the second edge after reset release.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      init_q        <= 1'b0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      aw_word_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
    end else begin
      init_q        <= 1'b1;
      S_AXI_AWREADY <= init_q && ((wr_next == WR_IDLE) || (wr_next == WR_HAVE_W));
      S_AXI_WREADY  <= init_q && ((wr_next == WR_IDLE) || (wr_next == WR_HAVE_AW));
      if (aw_hs) aw_word_q <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (commit) S_AXI_BRESP <= (wr_off <= OFFS_DROP_CNT) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ctrl_q    <= RST_CTRL;
      mac_lo_q  <= RST_MAC_LO;
      mac_hi_q  <= RST_MAC_HI;
      scratch_q <= RST_SCRATCH;
    end else if (commit) begin
      case (wr_off)
        OFFS_CTRL:    ctrl_q    <= apply_strb(ctrl_q, wr_data, wr_strb, MASK_CTRL);
        OFFS_MAC_LO:  mac_lo_q  <= apply_strb(mac_lo_q, wr_data, wr_strb, MASK_MAC_LO);
        OFFS_MAC_HI:  mac_hi_q  <= apply_strb(mac_hi_q, wr_data, wr_strb, MASK_MAC_HI);
        OFFS_SCRATCH: scratch_q <= apply_strb(scratch_q, wr_data, wr_strb, MASK_SCRATCH);
        default: ;
      endcase
    end
  end

  mac_filter_sat_counter #(.WIDTH(32)) u_drop_cnt (
    .clk   (ACLK),
    .rst   (ARESET),
    .inc   (drop_pulse),
    .clr   (commit && (wr_off == OFFS_DROP_CNT)),
    .count (drop_cnt)
  );

  assign filter_en = ctrl_q[0];
  assign promisc   = ctrl_q[1];
  assign mac_addr  = {mac_hi_q[15:0], mac_lo_q};

  always_comb begin
    rd_off  = 32'({S_AXI_ARADDR[ADDR_WIDTH-1:2], 2'b00});
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    case (rd_off)
      OFFS_CTRL:     rd_val = ctrl_q;
      OFFS_MAC_LO:   rd_val = mac_lo_q;
      OFFS_MAC_HI:   rd_val = mac_hi_q;
      OFFS_SCRATCH:  rd_val = scratch_q;
      OFFS_DROP_CNT: rd_val = drop_cnt;
      default:       rd_resp = RESP_SLVERR;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_RESP;
      RD_RESP: if (S_AXI_RREADY) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rd_state <= RD_IDLE;
    else        rd_state <= rd_next;
  end

  assign S_AXI_RVALID = (rd_state == RD_RESP);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      S_AXI_ARREADY <= init_q && (rd_next == RD_IDLE);
      if (ar_hs) begin
        S_AXI_RDATA <= rd_val;
        S_AXI_RRESP <= rd_resp;
      end
    end
  end

endmodule

// File: tb/tb_mac_filter_axil_regs.sv
// Directed bench for mac_filter_axil_regs: register map, channel ordering, strobes, drop counter, errors, reset.
module tb_mac_filter_axil_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        filter_en, promisc;
  logic [47:0] mac_addr;
  logic        drop_pulse = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  mac_filter_axil_regs #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .filter_en(filter_en), .promisc(promisc), .mac_addr(mac_addr), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic send_aw(input logic [4:0] a);
    int n = 0;
    awaddr = a; awvalid = 1'b1;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    check("aw_timeout", n < 20, 1);
    @(negedge clk); awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!wready && n < 20) begin @(negedge clk); n++; end
    check("w_timeout", n < 20, 1);
    @(negedge clk); wvalid = 1'b0;
  endtask

  task automatic send_both(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    check("aww_timeout", n < 20, 1);
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n = 0;
    bready = 1'b1;
    send_both(a, d, s);
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    check("b_timeout", n < 20, 1);
    resp = bresp;
    @(negedge clk); bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk); arvalid = 1'b0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    check("r_timeout", n < 20, 1);
    d = rdata; resp = rresp;
    @(negedge clk); rready = 1'b0;
  endtask

  // mode 0: W three cycles before AW; 1: AW three cycles before W; 2: together. BREADY low 4 cycles.
  task automatic ordered_write(input int mode, input logic [4:0] a, input logic [31:0] d);
    int ok = 0;
    bready = 1'b0;
    if (mode == 0) begin
      send_w(d, 4'hF);
      repeat (2) @(negedge clk);
      check("w_first_no_b", {bvalid, wready}, 2'b00);
      send_aw(a);
    end else if (mode == 1) begin
      send_aw(a);
      repeat (2) @(negedge clk);
      check("aw_first_no_b", {bvalid, awready}, 2'b00);
      send_w(d, 4'hF);
    end else begin
      send_both(a, d, 4'hF);
    end
    for (int c = 0; c < 4; c++) begin
      if (bvalid && !awready && !wready) ok++;
      @(negedge clk);
    end
    check("bvalid_hold", ok, 4);
    check("ord_bresp", bresp, 2'b00);
    bready = 1'b1;
    @(negedge clk); bready = 1'b0;
    check("bvalid_drop", bvalid, 0);
  endtask

  logic [31:0] rd;
  logic [1:0]  rr, br;

  initial begin
    // Reset state and ready timing.
    repeat (2) @(negedge clk);
    check("rst_valids", {awready, wready, arready, bvalid, rvalid}, 5'b0);
    check("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
    check("rst_cfg", {filter_en, promisc, mac_addr}, 50'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_edge1", {awready, wready, arready}, 3'b000);
    @(negedge clk);
    check("rdy_edge2", {awready, wready, arready}, 3'b111);

    // Basic write/readback.
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, br);
      check("basic_bresp", br, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), rd, rr);
      check("basic_rdata", rd, 32'(i + 1));
      check("basic_rresp", rr, 2'b00);
    end
    check("cfg_out", {filter_en, promisc, mac_addr}, {1'b1, 1'b0, 48'h0003_0000_0002});

    // Channel ordering with BREADY held off.
    ordered_write(0, 5'h0C, 32'h1111_1111);
    axi_read(5'h0C, rd, rr);
    check("w_first_data", rd, 32'h1111_1111);
    ordered_write(1, 5'h04, 32'h2222_2222);
    axi_read(5'h04, rd, rr);
    check("aw_first_data", rd, 32'h2222_2222);
    ordered_write(2, 5'h0C, 32'h3333_3333);
    axi_read(5'h0C, rd, rr);
    check("together_data", rd, 32'h3333_3333);

    // Writable masks and byte strobes.
    axi_write(5'h08, 32'hFFFF_FFFF, 4'hF, br);
    axi_read(5'h08, rd, rr);
    check("mac_hi_mask", rd, 32'h0000_FFFF);
    check("mac_addr_hi", mac_addr, 48'hFFFF_2222_2222);
    axi_write(5'h0C, 32'h0, 4'hF, br);
    axi_write(5'h0C, 32'hAABB_CCDD, 4'b0101, br);
    axi_read(5'h0C, rd, rr);
    check("strb_0101", rd, 32'h00BB_00DD);
    axi_write(5'h00, 32'h0000_0002, 4'h0, br);
    check("strb0_bresp", br, 2'b00);
    axi_read(5'h00, rd, rr);
    check("strb0_nochange", rd, 32'h1);

    // Read and commit on the same edge to the same register.
    awaddr = 5'h0C; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 5'h0C; arvalid = 1'b1; rready = 1'b1;
    check("same_edge_rdy", {awready, wready, arready}, 3'b111);
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("same_edge_valids", {bvalid, rvalid}, 2'b11);
    check("same_edge_old", rdata, 32'h00BB_00DD);
    @(negedge clk); bready = 1'b0; rready = 1'b0;
    axi_read(5'h0C, rd, rr);
    check("same_edge_new", rd, 32'h1234_5678);

    // Drop counter: count, clear-wins, saturation.
    for (int i = 0; i < 5; i++) begin
      drop_pulse = 1'b1; @(negedge clk); drop_pulse = 1'b0; @(negedge clk);
    end
    axi_read(5'h10, rd, rr);
    check("drop_cnt5", rd, 32'd5);
    awaddr = 5'h10; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    drop_pulse = 1'b1;
    check("clr_rdy", {awready, wready}, 2'b11);
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; drop_pulse = 1'b0;
    check("clr_bvalid", {bvalid, bresp}, 3'b100);
    @(negedge clk); bready = 1'b0;
    axi_read(5'h10, rd, rr);
    check("drop_clr_wins", rd, 32'd0);
    force dut.u_drop_cnt.count = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.u_drop_cnt.count;
    for (int i = 0; i < 3; i++) begin
      drop_pulse = 1'b1; @(negedge clk); drop_pulse = 1'b0; @(negedge clk);
    end
    axi_read(5'h10, rd, rr);
    check("drop_sat", rd, 32'hFFFF_FFFF);

    // Unmapped addresses.
    axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, br);
    check("unmapped_bresp", br, 2'b10);
    axi_read(5'h0C, rd, rr);
    check("unmapped_no_side", rd, 32'h1234_5678);
    axi_read(5'h18, rd, rr);
    check("unmapped_rresp", rr, 2'b10);
    check("unmapped_rdata", rd, 32'h0);

    // Reset with both responses pending.
    bready = 1'b0; rready = 1'b0;
    awaddr = 5'h0C; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h04; arvalid = 1'b1;
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("pre_rst_pending", {bvalid, rvalid}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("async_rst_drop", {bvalid, rvalid, awready, arready}, 4'b0);
    check("async_rst_cfg", {filter_en, mac_addr}, 49'h0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      axi_read(5'(i * 4), rd, rr);
      check("post_rst_reg", {rr, rd}, 34'h0);
    end
    axi_write(5'h00, 32'h2, 4'hF, br);
    check("post_rst_bresp", br, 2'b00);
    axi_read(5'h00, rd, rr);
    check("post_rst_read", rd, 32'h2);
    check("post_rst_cfg", {filter_en, promisc}, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
